// File: rtl/ntt_pkg.sv
// Shared NTT constants: coefficient list size, rotation stage count and a ceil-log2 helper.
package ntt_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  localparam int unsigned SIZE    = 257;
  localparam int unsigned NSTAGES = clog2(SIZE);

endpackage

// File: rtl/mod_reduce_size.sv
// Combinational reduction of a value below 3*SIZE into 0..SIZE-1 using two conditional subtractions.
module mod_reduce_size import ntt_pkg::*; #(
  parameter int unsigned SIZE = ntt_pkg::SIZE,
  localparam int unsigned IW  = clog2(3 * SIZE),
  localparam int unsigned OW  = clog2(SIZE)
) (
  input  logic [IW-1:0] x,
  output logic [OW-1:0] y_c
);

  logic [IW-1:0] s1;
  logic [IW-1:0] s2;

  always_comb begin
    s1  = (x >= IW'(SIZE)) ? x - IW'(SIZE) : x;
    s2  = (s1 >= IW'(SIZE)) ? s1 - IW'(SIZE) : s1;
    y_c = OW'(s2);
  end

endmodule

// File: rtl/rotation_sequencer.sv
// Issues per-stage shift enables for a binary-weighted rotation datapath, tracking a running offset
// and carrying each request's effective amount down an NSTAGES-deep, globally stalled pipeline.
module rotation_sequencer import ntt_pkg::*; #(
  parameter int unsigned SIZE    = ntt_pkg::SIZE,
  parameter int unsigned NSTAGES = clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NSTAGES-1:0] in_amount,
  input  logic               in_mode,
  input  logic               clear_offset,
  output logic [NSTAGES-1:0] stage_shift,
  output logic               stage_load,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NSTAGES-1:0] out_amount,
  output logic [NSTAGES-1:0] offset,
  output logic               busy
);

  localparam int unsigned SW = clog2(3 * SIZE);

  logic [NSTAGES-1:0] vld_q;
  logic [NSTAGES-1:0] vld_d;
  logic [NSTAGES-1:0] amt_q [NSTAGES];
  logic [NSTAGES-1:0] base_c;
  logic [SW-1:0]      sum_c;
  logic [NSTAGES-1:0] eff_c;
  logic               advance;
  logic               accept;

  // A same-cycle clear wins over the stored offset as the relative base.
  always_comb begin
    base_c = (in_mode && !clear_offset) ? offset : '0;
    sum_c  = SW'(base_c) + SW'(in_amount);
  end

  mod_reduce_size #(.SIZE(SIZE)) u_mod_reduce (
    .x   (sum_c),
    .y_c (eff_c)
  );

  assign advance    = !out_valid || out_ready;
  assign accept     = in_valid && advance;
  assign in_ready   = advance;
  assign stage_load = advance;
  assign out_valid  = vld_q[NSTAGES-1];
  assign out_amount = amt_q[NSTAGES-1];

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = advance ? accept : vld_q[0];
    for (int k = 1; k < NSTAGES; k++) begin
      vld_d[k] = advance ? vld_q[k-1] : vld_q[k];
    end
  end

  // Each entry's shift bit is pre-selected so stage k sees bit k of the amount it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      stage_shift <= '0;
      offset      <= '0;
      busy        <= 1'b0;
      for (int k = 0; k < NSTAGES; k++) amt_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      busy  <= |vld_d;
      if (advance) begin
        amt_q[0]       <= accept ? eff_c : '0;
        stage_shift[0] <= accept & eff_c[0];
        for (int k = 1; k < NSTAGES; k++) begin
          amt_q[k]       <= amt_q[k-1];
          stage_shift[k] <= vld_q[k-1] & amt_q[k-1][k];
        end
      end
      if (accept) begin
        offset <= eff_c;
      end else if (clear_offset) begin
        offset <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rotation_sequencer.sv
// Randomized and directed bench for rotation_sequencer against a queue-based latency/offset model.
module tb_rotation_sequencer;

  localparam int unsigned S = 257;
  localparam int unsigned N = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_amount;
  logic         in_mode;
  logic         clear_offset;
  logic [N-1:0] stage_shift;
  logic         stage_load;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_amount;
  logic [N-1:0] offset;
  logic         busy;

  rotation_sequencer #(.SIZE(S), .NSTAGES(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_amount    (in_amount),
    .in_mode      (in_mode),
    .clear_offset (clear_offset),
    .stage_shift  (stage_shift),
    .stage_load   (stage_load),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_amount   (out_amount),
    .offset       (offset),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned amt;
    int unsigned age;
  } ent_t;

  ent_t        q[$];
  int unsigned dq[$];
  int unsigned m_off;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare outputs against the model, then advance the model.
  task automatic step(input logic v, input int unsigned a, input logic m, input logic c,
                      input logic r);
    bit          exp_ov;
    bit          adv;
    int unsigned exp_shift;
    int unsigned base;
    int unsigned eff;
    @(negedge clk);
    in_valid     = v;
    in_amount    = N'(a);
    in_mode      = m;
    clear_offset = c;
    out_ready    = r;
    #1;
    exp_ov    = (q.size() > 0) && (q[0].age == N);
    exp_shift = 0;
    foreach (q[i]) exp_shift |= ((q[i].amt >> (q[i].age - 1)) & 1) << (q[i].age - 1);
    check("out_valid", int'(out_valid), int'(exp_ov));
    if (exp_ov) check("out_amount", int'(out_amount), q[0].amt);
    check("stage_shift", int'(stage_shift), exp_shift);
    check("offset", int'(offset), m_off);
    check("busy", int'(busy), int'(q.size() > 0));
    adv = !exp_ov || r;
    check("in_ready", int'(in_ready), int'(adv));
    check("stage_load", int'(stage_load), int'(adv));
    if (out_valid && out_ready) dq.push_back(int'(out_amount));
    @(posedge clk);
    base = c ? 0 : m_off;
    eff  = ((m ? base : 0) + a) % S;
    if (adv) begin
      if (exp_ov) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (v) q.push_back('{amt: eff, age: 1});
    end
    if (v && adv) m_off = eff;
    else if (c) m_off = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * N && q.size() > 0; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("drained", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_amount = '0; in_mode = 1'b0;
    clear_offset = 1'b0; out_ready = 1'b1; m_off = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_stage_load", int'(stage_load), 1);
    check("rst_offset", int'(offset), 0);
    check("rst_shift", int'(stage_shift), 0);
    check("rst_out_amount", int'(out_amount), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Absolute 5 through the full latency.
    step(1'b1, 5, 1'b0, 1'b0, 1'b1);
    #1 check("off_abs5", int'(offset), 5);
    drain();

    // Absolute reductions.
    step(1'b1, 300, 1'b0, 1'b0, 1'b1);
    #1 check("off_abs300", int'(offset), 43);
    step(1'b1, 256, 1'b0, 1'b0, 1'b1);
    #1 check("off_abs256", int'(offset), 256);
    step(1'b1, 257, 1'b0, 1'b0, 1'b1);
    #1 check("off_abs257", int'(offset), 0);
    drain();

    // Relative chain.
    step(1'b1, 200, 1'b0, 1'b0, 1'b1);
    step(1'b1, 100, 1'b1, 1'b0, 1'b1);
    #1 check("off_rel100", int'(offset), 43);
    step(1'b1, 511, 1'b1, 1'b0, 1'b1);
    #1 check("off_rel511", int'(offset), 40);
    drain();

    // Back-to-back burst with a 5-cycle downstream stall.
    dq.delete();
    for (int k = 1; k <= 9; k++) step(1'b1, k, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 77, 1'b0, 1'b0, 1'b0);
    drain();
    check("burst_count", dq.size(), 9);
    for (int k = 0; k < 9 && k < dq.size(); k++) check("burst_order", dq[k], k + 1);

    // Clear plus relative in one cycle.
    step(1'b1, 100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 7, 1'b1, 1'b1, 1'b1);
    #1 check("off_clear_rel", int'(offset), 7);
    drain();

    // Reset mid-flight.
    for (int k = 0; k < 4; k++) step(1'b1, 10 + k, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_offset", int'(offset), 0);
    check("midrst_shift", int'(stage_shift), 0);
    q.delete();
    m_off = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N + 3; k++) step(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Random traffic with random backpressure and clears.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 511), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotation_sequencer.md
ROTATION_SEQUENCER -- requirements
Module: rotation_sequencer

Interface
REQ-001 Parameter SIZE, default 257, number of coefficient slots in the rotated list (non-power-of-two allowed).
REQ-002 Parameter NSTAGES, default 9, number of binary-weighted shift stages, equal to ceil(log2(SIZE)); stage k rotates by 2^k slots.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  rotation request present.
REQ-006 Port in_ready  output  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 Port in_amount  input  NSTAGES  requested rotation, 0..2^NSTAGES-1.
REQ-008 Port in_mode  input  1  0 = absolute rotation, 1 = relative to the running offset.
REQ-009 Port clear_offset  input  1  synchronous clear of the running offset.
REQ-010 Port stage_shift  output  NSTAGES  bit k = shift enable for datapath stage k, aligned with the data held in pipeline stage k.
REQ-011 Port stage_load  output  1  load enable for all datapath pipeline registers this cycle.
REQ-012 Port out_valid  output  1  rotated result present at the last stage.
REQ-013 Port out_ready  input  1  downstream consumer accepts the result.
REQ-014 Port out_amount  output  NSTAGES  effective rotation applied to the result at the output.
REQ-015 Port offset  output  NSTAGES  current running offset, always in 0..SIZE-1.
REQ-016 Port busy  output  1  high when any pipeline stage holds a valid entry.

Function
REQ-017 The effective amount SHALL be in_amount mod SIZE (absolute) or (offset + in_amount) mod SIZE (relative), computed combinationally at acceptance.
REQ-018 Reduction SHALL use at most two conditional subtractions of SIZE, since the sum is below 3*SIZE; no divider.
REQ-019 On acceptance the offset register SHALL take the effective amount in both modes.
REQ-020 clear_offset SHALL zero the offset before a same-cycle acceptance is evaluated, so clear plus a relative request yields in_amount mod SIZE.
REQ-021 The pipeline SHALL have NSTAGES entries, each with a valid bit, the effective amount, and stage-position-aligned shift bits.
REQ-022 Entry k SHALL drive stage_shift[k] = bit k of the effective amount it carries, or 0 when that entry is invalid.
REQ-023 The advance condition SHALL be: !out_valid or out_ready; stage_load and in_ready SHALL both equal it (global stall).
REQ-024 A request accepted at edge t SHALL produce out_valid at edge t+NSTAGES, absent stalls; each stall cycle adds exactly one cycle.
REQ-025 The sequencer SHALL sustain one request per cycle with order preserved, and SHALL never drop or duplicate an entry under backpressure.
REQ-026 When the pipeline advances without acceptance, a bubble (valid 0) SHALL enter stage 0.
REQ-027 An effective amount of 0 SHALL still traverse the full latency with all shift bits clear.

Reset
REQ-028 While rst_n is low, all valid bits, offset, stage_shift, out_amount, out_valid and busy SHALL be 0; in_ready and stage_load SHALL then be 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries immediately; no out_valid pulse SHALL follow release.

Structure
REQ-030 SIZE, NSTAGES and a clog2 constant function SHALL live in the shared ntt package.
REQ-031 Modulo reduction SHALL be a sub-module mod_reduce_size (combinational, parameter SIZE), instantiated once.

Verification (SIZE=257, NSTAGES=9)
REQ-032 Absolute 5 accepted at t -> stage_shift[0] high at t+1, stage_shift[2] high at t+3, out_valid at t+9 with out_amount 5, offset 5.
REQ-033 Absolute 300 -> out_amount 43, offset 43; absolute 256 -> 256; absolute 257 -> 0 with no shift bits set.
REQ-034 Offset 200, relative 100 -> out_amount 43; then relative 511 -> (43+511) mod 257 = 40.
REQ-035 Nine back-to-back requests 1..9, out_ready held low 5 cycles once the pipe is full -> in_ready low for those cycles; outputs 1..9 in order, none lost.
REQ-036 Offset 100, clear_offset with relative 7 in the same cycle -> out_amount 7, offset 7.
REQ-037 rst_n pulsed low with 4 entries in flight -> busy 0 at once, no out_valid after release, offset 0.
